child_slot_arbiter: RTL and testbench

Round-robin arbiter that serialises access to a shared resource across the five child instances (slots 0-4) of a generated root module. Each child raises a request; the arbiter grants exactly one slot at a time and holds the grant until that slot signals completion. An optional watchdog forcibly revokes a grant that is never released. It sits one level above the child instances and is the only block that drives their grant lines.

---
 rtl/child_slot_arbiter_if.sv | 32 +++
 rtl/child_slot_arbiter.sv | 147 ++++++++++++++
 tb/tb_child_slot_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/child_slot_arbiter_if.sv
// rtl/child_slot_arbiter_if.sv - request/grant bundle between the slot arbiter and its child slots
interface child_slot_arbiter_if #(
  parameter int N_REQ = 5,
  parameter int ID_W  = 3
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [ID_W-1:0]  gnt_id;
  logic             timeout_pulse;

  // Arbiter side: samples requests/releases, drives the grant lines.
  modport master (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output timeout_pulse
  );

  // Child side: raises requests/releases, observes the grant lines.
  modport slave (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  timeout_pulse
  );
endinterface

// File: rtl/child_slot_arbiter.sv
// rtl/child_slot_arbiter.sv - round-robin grant-until-done arbiter for the child slots; ARB_WATCHDOG_EN adds forced release
module child_slot_arbiter #(
  parameter int N_REQ          = 5,
  parameter int ID_W           = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  child_slot_arbiter_if.master bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

  // Parameter sanity: an illegal configuration leaves a named, empty scope behind for inspection.
  if (TIMEOUT_CYCLES < 2 || (2 ** ID_W) < N_REQ) begin : g_bad_config
  end

  state_t           state, state_next;
  logic [N_REQ-1:0] gnt_q, gnt_next;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_next;
  logic [ID_W-1:0]  last_q, last_next;
  logic             pulse_q, pulse_next;

  logic             found;
  logic [ID_W-1:0]  winner;
  logic             done_hit;
  logic             req_hold;
  logic             release_now;

`ifdef ARB_WATCHDOG_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wd_cnt, wd_cnt_next;
`endif

  // Round-robin search: first requesting slot after the last winner, wrapping modulo N_REQ.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_v;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_v  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx   = (int'(last_q) + k) % N_REQ;
      idx_v = ID_W'(idx);
      if (!found && bus.req[idx_v]) begin
        found  = 1'b1;
        winner = idx_v;
      end
    end
  end

  // Only the granted slot's done/req bits matter; masking with gnt ignores all others.
  assign done_hit    = |(gnt_q & bus.done);
  assign req_hold    = |(gnt_q & bus.req);
  assign release_now = done_hit | ~req_hold;

  // Next-state and next-output decode for the IDLE/GRANT machine.
  always_comb begin
    state_next  = state;
    gnt_next    = gnt_q;
    gnt_id_next = gnt_id_q;
    last_next   = last_q;
    pulse_next  = 1'b0;
`ifdef ARB_WATCHDOG_EN
    wd_cnt_next = wd_cnt;
`endif
    case (state)
      IDLE: begin
        gnt_next    = '0;
        gnt_id_next = '0;
        if (found) begin
          state_next  = GRANT;
          gnt_next    = N_REQ'(1) << winner;
          gnt_id_next = winner;
          last_next   = winner;
`ifdef ARB_WATCHDOG_EN
          wd_cnt_next = '0;
`endif
        end
      end
      GRANT: begin
        if (release_now) begin
          state_next  = IDLE;
          gnt_next    = '0;
          gnt_id_next = '0;
`ifdef ARB_WATCHDOG_EN
        end else if (wd_cnt == WD_LAST) begin
          state_next  = IDLE;
          gnt_next    = '0;
          gnt_id_next = '0;
          pulse_next  = 1'b1;
        end else begin
          wd_cnt_next = wd_cnt + 1'b1;
`endif
        end
      end
      default: begin
        state_next  = IDLE;
        gnt_next    = '0;
        gnt_id_next = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      last_q   <= LAST_RST;
      pulse_q  <= 1'b0;
    end else begin
      state    <= state_next;
      gnt_q    <= gnt_next;
      gnt_id_q <= gnt_id_next;
      last_q   <= last_next;
      pulse_q  <= pulse_next;
    end
  end

`ifdef ARB_WATCHDOG_EN
  // Watchdog counter: cleared on grant entry, counts cycles spent in GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt_next;
    end
  end

  assign bus.timeout_pulse = pulse_q;
`else
  assign bus.timeout_pulse = 1'b0;
  logic unused_pulse;
  assign unused_pulse = pulse_q;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_child_slot_arbiter.sv
// tb/tb_child_slot_arbiter.sv - directed self-checking bench for child_slot_arbiter
module tb_child_slot_arbiter;

  localparam int N_REQ = 5;
  localparam int ID_W  = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  child_slot_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  child_slot_arbiter #(
    .N_REQ(N_REQ),
    .ID_W(ID_W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_grant(input string tag, input logic [4:0] g, input logic [2:0] id);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, "_id"}, 32'(bus.gnt_id), 32'(id));
    chk({tag, "_valid"}, 32'(bus.gnt_valid), 32'(g != 5'b0));
  endtask

  initial begin
    logic [2:0] order [6];
    logic [4:0] oh;
    int         bad;
    checks   = 0;
    failures = 0;
    order    = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    repeat (2) step();
    chk_grant("reset", 5'b00000, 3'd0);
    chk("reset_tp", 32'(bus.timeout_pulse), 32'd0);
    rst_n = 1'b1;
    step();

    // basic grant and handoff
    bus.req = 5'b10100;
    step();
    chk_grant("t1_first", 5'b00100, 3'd2);
    bus.done = 5'b00100;
    step();
    chk_grant("t1_gap", 5'b00000, 3'd0);
    bus.done = '0;
    step();
    chk_grant("t1_second", 5'b10000, 3'd4);
    bus.req = '0;
    step();
    chk_grant("t1_drop", 5'b00000, 3'd0);

    // wrap: last=4 so slot 0 first, then slot 4
    bus.req = 5'b10001;
    step();
    chk_grant("wrap_0", 5'b00001, 3'd0);
    bus.done = 5'b00001;
    step();
    chk_grant("wrap_gap", 5'b00000, 3'd0);
    bus.done = '0;
    step();
    chk_grant("wrap_4", 5'b10000, 3'd4);
    bus.req = '0;
    step();

    // all requesting, each grant held 3 cycles
    bus.req = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      oh = 5'b00001 << order[i];
      step();
      chk_grant($sformatf("rr_%0d", i), oh, order[i]);
      step();
      step();
      chk("rr_hold", 32'(bus.gnt), 32'(oh));
      if (i == 5) bus.req = '0;
      else bus.done = oh;
      step();
      chk("rr_gap", 32'(bus.gnt), 32'd0);
      bus.done = '0;
    end

    // other slots' done ignored, req drop releases
    bus.req = 5'b01000;
    step();
    chk_grant("t3_grant", 5'b01000, 3'd3);
    bus.done = 5'b00011;
    step();
    chk("t3_ignore_done", 32'(bus.gnt), 32'h08);
    bus.done = '0;
    step();
    chk("t3_still", 32'(bus.gnt), 32'h08);
    bus.req = '0;
    step();
    chk_grant("t3_drop", 5'b00000, 3'd0);

    // asynchronous reset mid-grant
    bus.req = 5'b00010;
    step();
    chk_grant("t4_grant", 5'b00010, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_grant("t4_async", 5'b00000, 3'd0);
    @(negedge clk);
    bus.req = 5'b00011;
    rst_n   = 1'b1;
    step();
    chk_grant("t4_after", 5'b00001, 3'd0);
    bus.req = '0;
    step();

    // stuck grant on slot 1 (last=0)
    bus.req = 5'b00010;
    step();
    chk_grant("wd_grant", 5'b00010, 3'd1);
`ifdef ARB_WATCHDOG_EN
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (bus.gnt !== 5'b00010 || bus.timeout_pulse !== 1'b0) bad++;
    end
    chk("wd_held7", 32'(bad), 32'd0);
    step();
    chk("wd_drop", 32'(bus.gnt), 32'd0);
    chk("wd_pulse", 32'(bus.timeout_pulse), 32'd1);
    step();
    chk("wd_pulse_end", 32'(bus.timeout_pulse), 32'd0);
    chk("wd_regrant", 32'(bus.gnt), 32'h02);
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.gnt !== 5'b00010 || bus.timeout_pulse !== 1'b0) bad++;
    end
    chk("nowd_held100", 32'(bad), 32'd0);
`endif
    bus.req = '0;
    step();
    chk_grant("wd_end", 5'b00000, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
